// File: rtl/mic_array_scheduler.sv
// I2S master for NUM_LINES stereo MEMS mic lines: generates SCK/WS, captures each slot and
// drains committed slots as a round-robin valid/ready stream tagged with channel index.
module mic_array_scheduler #(
  parameter int unsigned NUM_LINES   = 4,
  parameter int unsigned SCK_DIV     = 32,
  parameter int unsigned SAMPLE_BITS = 24
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           enable,
  input  logic [NUM_LINES-1:0]           mic_data,
  output logic                           mic_sck,
  output logic                           mic_ws,
  output logic [SAMPLE_BITS-1:0]         sample_out,
  output logic [$clog2(2*NUM_LINES)-1:0] sample_chan,
  output logic                           sample_valid,
  input  logic                           sample_ready,
  output logic                           frame_start,
  output logic                           overflow
);

  localparam int unsigned DivW  = $clog2(SCK_DIV);
  localparam int unsigned LineW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int unsigned PendW = $clog2(NUM_LINES + 1);
  localparam int unsigned ChanW = $clog2(2 * NUM_LINES);

  localparam logic [DivW-1:0]  RiseAt   = DivW'(SCK_DIV / 2 - 1);
  localparam logic [DivW-1:0]  LastDiv  = DivW'(SCK_DIV - 1);
  localparam logic [4:0]       LastPos  = 5'(SAMPLE_BITS);
  localparam logic [PendW-1:0] PendFull = PendW'(NUM_LINES);

  logic [DivW-1:0]        r_div_cnt;
  logic [5:0]             r_bit_cnt;
  logic                   r_sck;
  logic                   r_frame_start;
  logic                   r_first;
  logic [NUM_LINES-1:0]   r_data;
  logic [SAMPLE_BITS-1:0] r_shift [NUM_LINES];
  logic [SAMPLE_BITS-1:0] r_batch [NUM_LINES];
  logic [PendW-1:0]       r_pending;
  logic [LineW-1:0]       r_line;
  logic                   r_side;
  logic                   r_overflow;

  logic       w_rise;
  logic       w_fall;
  logic [4:0] w_pos;
  logic       w_capture;
  logic       w_commit;
  logic       w_valid;
  logic       w_xfer;

  assign w_rise    = enable && (r_div_cnt == RiseAt);
  assign w_fall    = enable && (r_div_cnt == LastDiv);
  assign w_pos     = r_bit_cnt[4:0];
  // I2S one-bit delay: MSB sits at slot position 1
  assign w_capture = w_rise && (w_pos != 5'd0) && (w_pos <= LastPos);
  assign w_commit  = w_fall && (w_pos == 5'd31);
  assign w_valid   = (r_pending != '0);
  assign w_xfer    = w_valid && sample_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_sck         <= 1'b0;
      r_frame_start <= 1'b0;
      r_first       <= 1'b1;
    end else if (!enable) begin
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_sck         <= 1'b0;
      r_frame_start <= 1'b0;
      r_first       <= 1'b1;
    end else begin
      r_div_cnt     <= w_fall ? '0 : r_div_cnt + 1'b1;
      r_frame_start <= w_fall && ((r_bit_cnt == 6'd63) || r_first);
      if (w_rise) begin
        r_sck <= 1'b1;
      end
      if (w_fall) begin
        r_sck     <= 1'b0;
        r_bit_cnt <= r_bit_cnt + 6'd1;
        r_first   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_data <= '0;
      for (int i = 0; i < int'(NUM_LINES); i++) begin
        r_shift[i] <= '0;
      end
    end else begin
      r_data <= mic_data;
      for (int i = 0; i < int'(NUM_LINES); i++) begin
        if (!enable) begin
          r_shift[i] <= '0;
        end else if (w_capture) begin
          r_shift[i] <= {r_shift[i][SAMPLE_BITS-2:0], r_data[i]};
        end
      end
    end
  end

  // A new commit always wins: the unsent tail of the old batch is dropped.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(NUM_LINES); i++) begin
        r_batch[i] <= '0;
      end
      r_pending  <= '0;
      r_line     <= '0;
      r_side     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_commit) begin
      r_batch   <= r_shift;
      r_pending <= PendFull;
      r_line    <= '0;
      r_side    <= r_bit_cnt[5];
      if (w_valid && !((r_pending == PendW'(1)) && w_xfer)) begin
        r_overflow <= 1'b1;
      end
    end else if (w_xfer) begin
      r_pending <= r_pending - 1'b1;
      r_line    <= r_line + 1'b1;
    end
  end

  assign mic_sck      = r_sck;
  assign mic_ws       = r_bit_cnt[5];
  assign frame_start  = r_frame_start;
  assign overflow     = r_overflow;
  assign sample_valid = w_valid;
  assign sample_out   = r_batch[r_line];
  assign sample_chan  = ChanW'({r_line, r_side});

endmodule

// File: tb/tb_mic_array_scheduler.sv
// Bench for mic_array_scheduler: a microphone model drives slot data from sample tables and a
// scoreboard predicts the drained stream, overflow, WS and frame_start every cycle.
`timescale 1ns/1ps
module tb_mic_array_scheduler;
  localparam int NL = 4;
  localparam int SB = 24;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          enable = 1'b0;
  logic [NL-1:0] mic_data = '0;
  logic          sample_ready = 1'b1;
  logic          mic_sck, mic_ws, sample_valid, frame_start, overflow;
  logic [SB-1:0] sample_out;
  logic [2:0]    sample_chan;

  mic_array_scheduler #(.NUM_LINES(NL), .SCK_DIV(32), .SAMPLE_BITS(SB)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .enable      (enable),
    .mic_data    (mic_data),
    .mic_sck     (mic_sck),
    .mic_ws      (mic_ws),
    .sample_out  (sample_out),
    .sample_chan (sample_chan),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .frame_start (frame_start),
    .overflow    (overflow)
  );

  initial forever #5 clk_in = ~clk_in;

  typedef struct {
    int            chan;
    logic [SB-1:0] val;
  } exp_t;

  exp_t          q[$];
  logic [SB-1:0] left_tab[NL];
  logic [SB-1:0] right_tab[NL];
  logic [SB-1:0] slot_vals[NL];
  int            pos = 0;
  bit            side = 0, m_first = 1, m_ovf = 0, prev_sck = 0, prev_en = 0, exp_fs = 0;
  int            mode = 0;
  int            n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic relatch();
    for (int l = 0; l < NL; l++) slot_vals[l] = side ? right_tab[l] : left_tab[l];
  endtask

  // Mic drives the bit for the current slot position; positions outside the sample get junk.
  task automatic drive();
    logic [SB-1:0] v;
    for (int l = 0; l < NL; l++) begin
      v = slot_vals[l];
      if (pos >= 1 && pos <= SB) mic_data[l] = v[SB-pos];
      else if (pos == 0)         mic_data[l] = ~v[SB-1];
      else                       mic_data[l] = ~v[0];
    end
  endtask

  // Model and per-cycle compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      exp_fs = 1'b0;
      if (rst_in) begin
        q.delete();
        m_ovf = 0; pos = 0; side = 0; m_first = 1;
        relatch();
      end else if (!prev_en) begin
        pos = 0; side = 0; m_first = 1;
        relatch();
      end else if (prev_sck && !mic_sck) begin
        exp_fs  = m_first || (side && pos == 31);
        m_first = 0;
        if (pos == 31) begin
          if (q.size() != 0) begin
            m_ovf = 1;
            q.delete();
          end
          for (int l = 0; l < NL; l++) begin
            e.chan = 2 * l + int'(side);
            e.val  = slot_vals[l];
            q.push_back(e);
          end
          side = ~side;
          pos  = 0;
          relatch();
        end else begin
          pos++;
        end
      end
      chk("valid", {31'd0, sample_valid}, {31'd0, q.size() != 0});
      if (sample_valid && q.size() != 0) begin
        chk("chan", {29'd0, sample_chan}, q[0].chan);
        chk("data", {8'd0, sample_out}, {8'd0, q[0].val});
      end
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
      chk("ws", {31'd0, mic_ws}, {31'd0, side});
      if (sample_valid && sample_ready && q.size() != 0) void'(q.pop_front());
      drive();
      prev_sck = mic_sck;
      prev_en  = enable && !rst_in;
    end
  end

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      case (mode)
        0:       sample_ready = 1'b1;
        1:       sample_ready = 1'b0;
        default: sample_ready = ~sample_ready;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint t0, t1, t2;
    int n;
    for (int l = 0; l < NL; l++) begin
      left_tab[l]  = 24'h800000;
      right_tab[l] = 24'h800000;
    end
    left_tab[0]  = 24'h0A0000;
    right_tab[0] = 24'h7FFFFF;

    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_sck", {31'd0, mic_sck}, 0);
    chk("rst_ws", {31'd0, mic_ws}, 0);
    chk("rst_valid", {31'd0, sample_valid}, 0);
    chk("rst_fs", {31'd0, frame_start}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    enable = 1'b1;

    // Bus timing
    @(negedge mic_sck);
    @(negedge clk_in);
    chk("first_fall_fs", {31'd0, frame_start}, 1);
    @(posedge mic_sck); t0 = $time;
    @(negedge mic_sck); t1 = $time;
    @(posedge mic_sck); t2 = $time;
    chk("sck_high_ns", 32'(t1 - t0), 160);
    chk("sck_period_ns", 32'(t2 - t0), 320);

    // First left batch, then the right batch
    @(posedge mic_ws); t0 = $time;
    @(negedge clk_in);
    chk("left0_chan", {29'd0, sample_chan}, 0);
    chk("left0_val", {8'd0, sample_out}, 32'h0A0000);
    @(negedge clk_in);
    chk("left1_chan", {29'd0, sample_chan}, 2);
    chk("left1_val", {8'd0, sample_out}, 32'h800000);
    @(negedge mic_ws); t1 = $time;
    chk("ws_high_ns", 32'(t1 - t0), 10240);
    @(negedge clk_in);
    chk("right0_chan", {29'd0, sample_chan}, 1);
    chk("right0_val", {8'd0, sample_out}, 32'h7FFFFF);
    @(posedge frame_start); t0 = $time;
    @(posedge frame_start); t1 = $time;
    chk("frame_ns", 32'(t1 - t0), 20480);

    // Ready toggling every cycle
    repeat (50) @(posedge clk_in);
    #1 mode = 2;
    @(posedge mic_ws);
    @(negedge mic_ws);
    repeat (20) @(posedge clk_in);
    @(negedge clk_in);
    chk("toggle_no_ovf", {31'd0, overflow}, 0);

    // Two slots without ready
    #1 mode = 1;
    @(posedge mic_ws);
    @(negedge mic_ws);
    @(negedge clk_in);
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_valid", {31'd0, sample_valid}, 1);
    chk("ovf_chan", {29'd0, sample_chan}, 1);
    chk("ovf_val", {8'd0, sample_out}, 32'h7FFFFF);
    #1 mode = 0;

    // Disable at bit_cnt 42 (right slot, position 10), then re-enable
    @(posedge mic_ws);
    repeat (10) @(negedge mic_sck);
    @(posedge mic_sck);
    @(negedge clk_in);
    chk("pre_drop_ws", {31'd0, mic_ws}, 1);
    chk("pre_drop_sck", {31'd0, mic_sck}, 1);
    @(posedge clk_in);
    #1 enable = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("drop_sck", {31'd0, mic_sck}, 0);
    chk("drop_ws", {31'd0, mic_ws}, 0);
    repeat (200) @(posedge clk_in);
    @(negedge clk_in);
    chk("idle_no_valid", {31'd0, sample_valid}, 0);
    @(posedge clk_in);
    #1 enable = 1'b1;
    n = 0;
    do begin
      @(posedge clk_in);
      n++;
      @(negedge clk_in);
    end while (!sample_valid && n < 1100);
    chk("reen_latency", n, 1024);
    chk("reen_chan", {29'd0, sample_chan}, 0);
    chk("reen_val", {8'd0, sample_out}, 32'h0A0000);

    // Async reset while a batch is stalled
    mode = 1;
    repeat (3) @(negedge clk_in);
    chk("pre_rst_valid", {31'd0, sample_valid}, 1);
    #2 rst_in = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, sample_valid}, 0);
    chk("rst_async_ovf", {31'd0, overflow}, 0);
    repeat (3) @(negedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    enable = 1'b0;
    mode = 0;
    repeat (20) @(posedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
